snake_body: RTL and testbench

SNAKE_BODY -- requirements
Module: snake_body

---
 rtl/snake_pkg.sv | 44 ++++
 rtl/snake_body_next_head.sv | 58 +++++
 rtl/snake_body.sv | 141 ++++++++++++++
 tb/tb_snake_body.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// snake_pkg: shared types and constants for the snake_body design.
//   dir_t    - heading encoding (0 up, 1 right, 2 down, 3 left)
//   state_t  - game FSM states
//   pos_t    - one segment position, {row[7:4], col[3:0]}
//   init_body() - the segment array loaded on reset and on restart
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2
  } state_t;

  typedef logic [7:0] pos_t;

  localparam int         GRID_DIM  = 16;
  localparam int         NUM_SEG   = 256;
  localparam logic [7:0] INIT_LEN  = 8'd3;
  localparam pos_t       INIT_HEAD = 8'h88;
  localparam logic [7:0] MAX_LEN   = 8'd255;

  // Opposite headings differ only in bit 1 (up/down, right/left).
  function automatic logic is_opposite(input dir_t a, input dir_t b);
    return (logic'(a[1] != b[1]) && (a[0] == b[0]));
  endfunction

  // Initial snake: head at 88 trailing left (87, 86); residue cleared.
  function automatic logic [NUM_SEG-1:0][7:0] init_body();
    logic [NUM_SEG-1:0][7:0] p;
    p    = '0;
    p[0] = INIT_HEAD;
    p[1] = INIT_HEAD - 8'd1;
    p[2] = INIT_HEAD - 8'd2;
    return p;
  endfunction

endpackage

// File: rtl/snake_body_next_head.sv
// next_head: combinational head-advance for the snake.
// Ports:
//   head     in  current head {row, col}
//   heading  in  direction to move
//   new_head out head after one move (4-bit row/col wrap naturally mod 16)
//   wall     out move would leave the 16x16 grid
// Build macro SNAKE_WRAP_EN: when defined, edges wrap and wall is never set.
module next_head
  import snake_pkg::*;
(
  input  pos_t head,
  input  dir_t heading,
  output pos_t new_head,
  output logic wall
);

  localparam logic [3:0] EDGE_MAX = 4'(GRID_DIM - 1);

  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] new_row;
  logic [3:0] new_col;
  logic       edge_hit;

  always_comb begin
    row      = head[7:4];
    col      = head[3:0];
    new_row  = row;
    new_col  = col;
    edge_hit = 1'b0;
    case (heading)
      DIR_UP: begin
        new_row  = row - 4'd1;
        edge_hit = (row == 4'd0);
      end
      DIR_RIGHT: begin
        new_col  = col + 4'd1;
        edge_hit = (col == EDGE_MAX);
      end
      DIR_DOWN: begin
        new_row  = row + 4'd1;
        edge_hit = (row == EDGE_MAX);
      end
      default: begin
        new_col  = col - 4'd1;
        edge_hit = (col == 4'd0);
      end
    endcase
    new_head = {new_row, new_col};
  end

`ifdef SNAKE_WRAP_EN
  assign wall = 1'b0;
`else
  assign wall = edge_hit;
`endif

endmodule

// File: rtl/snake_body.sv
// snake_body: snake game body tracker (segment shift register + game FSM).
// Ports:
//   clk        in  system clock, all state on rising edge
//   reset      in  synchronous active-high reset
//   start      in  start/restart pulse
//   step       in  move tick (only acted on in RUN)
//   dir        in  requested heading (reversal requests are ignored)
//   grow       in  lengthen on this move (saturates at 255)
//   pos        out segment positions, pos[0] = head, {row, col}
//   length     out number of valid segments
//   moved      out one-cycle pulse after each successful move
//   game_over  out high while DEAD
// Build macro SNAKE_WRAP_EN (honoured in next_head): wrap at grid edges.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | initial snake loaded, waiting for start
// ST_RUN  | moving on each step, collision checked
// ST_DEAD | collision seen, everything frozen until start
module snake_body
  import snake_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    step,
  input  logic [1:0]              dir,
  input  logic                    grow,
  output logic [NUM_SEG-1:0][7:0] pos,
  output logic [7:0]              length,
  output logic                    moved,
  output logic                    game_over
);

  state_t                  state_q, state_d;
  dir_t                    heading_q, heading_d;
  logic [NUM_SEG-1:0][7:0] pos_q, pos_d;
  logic [7:0]              length_q, length_d;
  logic                    moved_q, moved_d;
  logic                    game_over_q, game_over_d;

  dir_t       req_dir;
  dir_t       heading_try;
  pos_t       new_head;
  logic       wall;
  logic       eff_grow;
  logic [8:0] seg_limit;
  logic       self_hit;
  logic       collide;

  always_comb begin
    req_dir     = dir_t'(dir);
    heading_try = is_opposite(req_dir, heading_q) ? heading_q : req_dir;
  end

  next_head u_next_head (
    .head     (pos_q[0]),
    .heading  (heading_try),
    .new_head (new_head),
    .wall     (wall)
  );

  // The tail segment vacates its cell on a non-growing move, so it is
  // excluded from the self-collision search unless the snake grows.
  always_comb begin
    eff_grow  = grow && (length_q != MAX_LEN);
    seg_limit = eff_grow ? {1'b0, length_q} : ({1'b0, length_q} - 9'd1);
    self_hit  = 1'b0;
    for (int i = 0; i < NUM_SEG; i++) begin
      if ((i < int'(seg_limit)) && (pos_q[i] == new_head)) begin
        self_hit = 1'b1;
      end
    end
    collide = wall | self_hit;
  end

  always_comb begin
    state_d   = state_q;
    heading_d = heading_q;
    pos_d     = pos_q;
    length_d  = length_q;
    moved_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (step) begin
          if (collide) begin
            state_d = ST_DEAD;
          end else begin
            heading_d = heading_try;
            pos_d     = {pos_q[NUM_SEG-2:0], new_head};
            if (eff_grow) begin
              length_d = length_q + 8'd1;
            end
            moved_d = 1'b1;
          end
        end
      end
      ST_DEAD: begin
        if (start) begin
          state_d   = ST_IDLE;
          heading_d = DIR_RIGHT;
          pos_d     = init_body();
          length_d  = INIT_LEN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    game_over_d = (state_d == ST_DEAD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      heading_q   <= DIR_RIGHT;
      pos_q       <= init_body();
      length_q    <= INIT_LEN;
      moved_q     <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      heading_q   <= heading_d;
      pos_q       <= pos_d;
      length_q    <= length_d;
      moved_q     <= moved_d;
      game_over_q <= game_over_d;
    end
  end

  assign pos       = pos_q;
  assign length    = length_q;
  assign moved     = moved_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_snake_body.sv
// tb_snake_body: directed and random checks of snake_body against a
// queue-based model of the game rules.
module tb_snake_body;

  logic                clk;
  logic                reset;
  logic                start;
  logic                step;
  logic [1:0]          dir;
  logic                grow;
  logic [255:0][7:0]   pos;
  logic [7:0]          length;
  logic                moved;
  logic                game_over;

  snake_body dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .step      (step),
    .dir       (dir),
    .grow      (grow),
    .pos       (pos),
    .length    (length),
    .moved     (moved),
    .game_over (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // Model: body as a queue of {row,col}, head first; 0 idle, 1 run, 2 dead.
  logic [7:0] body[$];
  int         m_state;
  int         m_hd;
  bit         m_moved;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_init();
    body    = {8'h88, 8'h87, 8'h86};
    m_state = 0;
    m_hd    = 1;
  endtask

  task automatic model_update(input bit rst, input bit st, input bit sp,
                              input logic [1:0] d, input bit g);
    int  h, r, c, lim;
    bit  wall, hit, eg;
    m_moved = 0;
    if (rst) begin
      model_init();
    end else if (m_state == 0) begin
      if (st) m_state = 1;
    end else if (m_state == 2) begin
      if (st) model_init();
    end else if (sp) begin
      h = ((int'(d) + 2) % 4 == m_hd) ? m_hd : int'(d);
      r = int'(body[0][7:4]);
      c = int'(body[0][3:0]);
      if (h == 0) r = r - 1;
      else if (h == 1) c = c + 1;
      else if (h == 2) r = r + 1;
      else c = c - 1;
      wall = (r < 0) || (r > 15) || (c < 0) || (c > 15);
`ifdef SNAKE_WRAP_EN
      r = (r + 16) % 16;
      c = (c + 16) % 16;
      wall = 0;
`endif
      eg  = g && (body.size() < 255);
      lim = eg ? body.size() : body.size() - 1;
      hit = 0;
      for (int i = 0; i < lim; i++) begin
        if (body[i] == 8'(r * 16 + c)) hit = 1;
      end
      if (wall || hit) begin
        m_state = 2;
      end else begin
        body.push_front(8'(r * 16 + c));
        if (!eg) void'(body.pop_back());
        m_hd    = h;
        m_moved = 1;
      end
    end
  endtask

  task automatic check_all();
    chk("length", 32'(length), 32'(body.size()));
    chk("game_over", 32'(game_over), 32'(m_state == 2));
    chk("moved", 32'(moved), 32'(m_moved));
    for (int i = 0; i < body.size(); i++) begin
      chk($sformatf("pos[%0d]", i), 32'(pos[i]), 32'(body[i]));
    end
  endtask

  // One clock: drive after a falling edge, update model at the rising
  // edge, check on the next falling edge.
  task automatic tick(input bit rst, input bit st, input bit sp,
                      input logic [1:0] d, input bit g);
    reset = rst;
    start = st;
    step  = sp;
    dir   = d;
    grow  = g;
    @(posedge clk);
    model_update(rst, st, sp, d, g);
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    step  = 1'b0;
    grow  = 1'b0;
    check_all();
  endtask

  initial begin
    bit          rst, st, sp, g;
    logic [1:0]  d;
    reset = 1'b1;
    start = 1'b0;
    step  = 1'b0;
    dir   = 2'd0;
    grow  = 1'b0;
    model_init();
    m_moved = 0;
    @(negedge clk);

    // reset values, step ignored in IDLE
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    chk("rst_len", 32'(length), 32'd3);
    chk("rst_p0", 32'(pos[0]), 32'h88);
    chk("rst_p1", 32'(pos[1]), 32'h87);
    chk("rst_p2", 32'(pos[2]), 32'h86);
    chk("rst_p3", 32'(pos[3]), 32'h00);
    tick(0, 0, 1, 1, 0);
    chk("idle_step_p0", 32'(pos[0]), 32'h88);
    chk("idle_step_moved", 32'(moved), 32'd0);

    // two moves right
    tick(0, 1, 0, 0, 0);
    tick(0, 0, 1, 1, 0);
    chk("mv1_moved", 32'(moved), 32'd1);
    tick(0, 0, 1, 1, 0);
    chk("mv2_moved", 32'(moved), 32'd1);
    chk("mv2_p0", 32'(pos[0]), 32'h8A);
    chk("mv2_p1", 32'(pos[1]), 32'h89);
    chk("mv2_p2", 32'(pos[2]), 32'h88);
    chk("mv2_len", 32'(length), 32'd3);
    tick(0, 0, 0, 0, 0);
    chk("mv_pulse_end", 32'(moved), 32'd0);

    // growth upward
    tick(1, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    tick(0, 0, 1, 0, 1);
    chk("grow_p0", 32'(pos[0]), 32'h78);
    chk("grow_len", 32'(length), 32'd4);

    // reversal request ignored
    tick(1, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    tick(0, 0, 1, 1, 0);
    tick(0, 0, 1, 3, 0);
    chk("rev_p0", 32'(pos[0]), 32'h8A);

    // start and step together in IDLE: start wins, no move
    tick(1, 0, 0, 0, 0);
    tick(0, 1, 1, 1, 0);
    chk("ss_p0", 32'(pos[0]), 32'h88);
    chk("ss_moved", 32'(moved), 32'd0);
    tick(0, 0, 1, 1, 0);
    chk("ss_run_p0", 32'(pos[0]), 32'h89);

    // right wall
    tick(1, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) tick(0, 0, 1, 1, 0);
    chk("wall_pre_p0", 32'(pos[0]), 32'h8F);
    tick(0, 0, 1, 1, 0);
`ifdef SNAKE_WRAP_EN
    chk("wrap_p0", 32'(pos[0]), 32'h80);
    chk("wrap_go", 32'(game_over), 32'd0);
`else
    chk("wall_go", 32'(game_over), 32'd1);
    chk("wall_p0", 32'(pos[0]), 32'h8F);
    chk("wall_moved", 32'(moved), 32'd0);
    tick(0, 1, 0, 0, 0);
    chk("restart_go", 32'(game_over), 32'd0);
    chk("restart_p0", 32'(pos[0]), 32'h88);
    chk("restart_len", 32'(length), 32'd3);
`endif

    // self-collision
    tick(1, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    tick(0, 0, 1, 1, 1);
    tick(0, 0, 1, 1, 1);
    chk("sc_len5", 32'(length), 32'd5);
    tick(0, 0, 1, 0, 0);
    tick(0, 0, 1, 3, 0);
    tick(0, 0, 1, 2, 0);
    chk("sc_go", 32'(game_over), 32'd1);
    chk("sc_len", 32'(length), 32'd5);
    chk("sc_p0", 32'(pos[0]), 32'h79);
    tick(0, 0, 1, 1, 0);
    chk("dead_step_p0", 32'(pos[0]), 32'h79);
    tick(0, 1, 0, 0, 0);
    chk("sc_restart_p1", 32'(pos[1]), 32'h87);

    // reset mid-game overrides start/step
    tick(0, 1, 0, 0, 0);
    tick(0, 0, 1, 2, 1);
    tick(0, 0, 1, 2, 0);
    tick(1, 1, 1, 1, 1);
    chk("midrst_len", 32'(length), 32'd3);
    chk("midrst_p0", 32'(pos[0]), 32'h88);
    chk("midrst_p3", 32'(pos[3]), 32'h00);
    chk("midrst_moved", 32'(moved), 32'd0);

    // random play
    for (int n = 0; n < 2000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      st  = (m_state == 1) ? ($urandom_range(0, 19) == 0)
                           : ($urandom_range(0, 3) == 0);
      sp  = ($urandom_range(0, 9) < 7);
      d   = 2'($urandom_range(0, 3));
      g   = ($urandom_range(0, 3) == 0);
      tick(rst, st, sp, d, g);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
